// File: rtl/serial_slave_port.sv
// serial_slave_port: slave-side endpoint of the serial system bus.
// Deserialises an MSB-first address (and write data) from wr_bus, performs
// one word access on a synchronous memory port, and for reads serialises the
// returned word MSB-first on rd_bus.
//
// Handshake: an inbound bit transfers on a rising edge where
// master_valid && slave_ready; an outbound bit transfers on a rising edge
// where slave_valid && master_ready. A valid side holds its bit stable until
// the transfer happens; ready/valid never depend combinationally on the
// other side's signal. slave_ready and slave_valid are never both high.
module serial_slave_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mode,
  input  logic                  wr_bus,
  input  logic                  master_valid,
  output logic                  slave_ready,
  input  logic                  master_ready,
  output logic                  slave_valid,
  output logic                  rd_bus,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [2:0]            dbg_state
);

  localparam int MAXW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int IW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ADDR   = 3'd1,
    WDATA  = 3'd2,
    WRITE  = 3'd3,
    RFETCH = 3'd4,
    RLOAD  = 3'd5,
    RDATA  = 3'd6
  } state_t;

  state_t                r_state;
  logic                  r_mode;
  logic [ADDR_WIDTH-1:0] r_addr_sr;
  logic [DATA_WIDTH-1:0] r_data_sr;
  logic [DATA_WIDTH-1:0] r_rd_sr;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idle;
  logic                  r_slave_ready;
  logic                  r_slave_valid;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_mem_we;
  logic                  r_mem_re;

  logic                  w_in_beat;
  logic                  w_out_beat;
  logic                  w_stall_expired;

  assign w_in_beat       = master_valid & r_slave_ready;
  assign w_out_beat      = r_slave_valid & master_ready;
  assign w_stall_expired = (r_idle == IW'(TIMEOUT - 1));

  // Transaction FSM: shift registers, counters, strobes and handshake flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_mode        <= 1'b0;
      r_addr_sr     <= '0;
      r_data_sr     <= '0;
      r_rd_sr       <= '0;
      r_cnt         <= '0;
      r_idle        <= '0;
      r_slave_ready <= 1'b0;
      r_slave_valid <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_we      <= 1'b0;
      r_mem_re      <= 1'b0;
    end else begin
      // Strobes are single-cycle: raised on entry to WRITE/RFETCH only.
      r_mem_we <= 1'b0;
      r_mem_re <= 1'b0;
      case (r_state)
        IDLE: begin
          r_slave_ready <= 1'b1;
          r_slave_valid <= 1'b0;
          r_idle        <= '0;
          if (w_in_beat) begin
            r_addr_sr <= ADDR_WIDTH'(wr_bus);
            r_mode    <= mode;
            r_cnt     <= CW'(1);
            r_state   <= ADDR;
          end
        end
        ADDR: begin
          if (w_in_beat) begin
            r_addr_sr <= {r_addr_sr[ADDR_WIDTH-2:0], wr_bus};
            r_idle    <= '0;
            if (r_cnt == CW'(ADDR_WIDTH - 1)) begin
              r_cnt <= '0;
              if (r_mode) begin
                r_state <= WDATA;
              end else begin
                // Full address known: issue the read strobe next cycle.
                r_state       <= RFETCH;
                r_slave_ready <= 1'b0;
                r_mem_re      <= 1'b1;
                r_mem_addr    <= {r_addr_sr[ADDR_WIDTH-2:0], wr_bus};
              end
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end else if (w_stall_expired) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idle  <= '0;
          end else begin
            r_idle <= r_idle + IW'(1);
          end
        end
        WDATA: begin
          if (w_in_beat) begin
            r_data_sr <= {r_data_sr[DATA_WIDTH-2:0], wr_bus};
            r_idle    <= '0;
            if (r_cnt == CW'(DATA_WIDTH - 1)) begin
              r_state       <= WRITE;
              r_cnt         <= '0;
              r_slave_ready <= 1'b0;
              r_mem_we      <= 1'b1;
              r_mem_addr    <= r_addr_sr;
              r_mem_wdata   <= {r_data_sr[DATA_WIDTH-2:0], wr_bus};
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end else if (w_stall_expired) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idle  <= '0;
          end else begin
            r_idle <= r_idle + IW'(1);
          end
        end
        WRITE: begin
          r_slave_ready <= 1'b1;
          r_state       <= IDLE;
        end
        RFETCH: begin
          r_state <= RLOAD;
        end
        RLOAD: begin
          // Memory returns data the cycle after mem_re.
          r_rd_sr       <= mem_rdata;
          r_slave_valid <= 1'b1;
          r_cnt         <= '0;
          r_idle        <= '0;
          r_state       <= RDATA;
        end
        RDATA: begin
          if (w_out_beat) begin
            r_rd_sr <= r_rd_sr << 1;
            r_idle  <= '0;
            if (r_cnt == CW'(DATA_WIDTH - 1)) begin
              r_state       <= IDLE;
              r_cnt         <= '0;
              r_slave_valid <= 1'b0;
              r_slave_ready <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end else if (w_stall_expired) begin
            r_state       <= IDLE;
            r_cnt         <= '0;
            r_idle        <= '0;
            r_rd_sr       <= '0;
            r_slave_valid <= 1'b0;
            r_slave_ready <= 1'b1;
          end else begin
            r_idle <= r_idle + IW'(1);
          end
        end
        default: begin
          r_state       <= IDLE;
          r_slave_ready <= 1'b1;
          r_slave_valid <= 1'b0;
        end
      endcase
    end
  end

  assign slave_ready = r_slave_ready;
  assign slave_valid = r_slave_valid;
  assign rd_bus      = r_slave_valid & r_rd_sr[DATA_WIDTH-1];
  assign mem_addr    = r_mem_addr;
  assign mem_wdata   = r_mem_wdata;
  assign mem_we      = r_mem_we;
  assign mem_re      = r_mem_re;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_serial_slave_port.sv
// Directed bench for serial_slave_port with a small storage model and
// scoreboards for write strobes and serialised read data.
module tb_serial_slave_port;

  localparam int AW = 12;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mode = 1'b0;
  logic          wr_bus = 1'b0;
  logic          master_valid = 1'b0;
  logic          master_ready = 1'b0;
  logic          slave_ready;
  logic          slave_valid;
  logic          rd_bus;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [DW-1:0] mem_rdata = '0;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_err    = 0;
  int re_count = 0;
  bit overlap_seen = 1'b0;

  logic [DW-1:0]    mem [0:(1<<AW)-1];
  logic [AW+DW-1:0] exp_q[$];
  logic [DW-1:0]    rd_exp_q[$];
  logic [AW+DW-1:0] wr_e;

  serial_slave_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .mode(mode), .wr_bus(wr_bus),
    .master_valid(master_valid), .slave_ready(slave_ready),
    .master_ready(master_ready), .slave_valid(slave_valid), .rd_bus(rd_bus),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // storage model: preload one word during reset, write on mem_we, read data next cycle
  always @(posedge clk) begin
    if (rst) mem[12'h012] <= 8'h3C;
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // write-strobe scoreboard and handshake monitor
  always @(negedge clk) begin
    if (slave_ready && slave_valid) overlap_seen = 1'b1;
    if (mem_re) re_count++;
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", {31'd0, mem_we}, 32'd0);
      end else begin
        wr_e = exp_q.pop_front();
        chk("wr_txn", {12'd0, mem_addr, mem_wdata}, {12'd0, wr_e});
      end
    end
  end

  // driver tasks
  task automatic send_bit(input logic b, input logic m);
    int t;
    t = 0;
    @(negedge clk);
    mode = m; wr_bus = b; master_valid = 1'b1;
    while (!slave_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (t >= 40) chk("beat_wait", {31'd0, slave_ready}, 32'd1);
    @(posedge clk);
    #1;
    master_valid = 1'b0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit stall);
    exp_q.push_back({a, d});
    for (int i = AW - 1; i >= 0; i--) begin
      if (stall && i != AW - 1) @(negedge clk);
      send_bit(a[i], 1'b1);
    end
    for (int i = DW - 1; i >= 0; i--) begin
      if (stall) @(negedge clk);
      send_bit(d[i], 1'b1);
    end
    @(negedge clk);
    chk("we_strobe", {31'd0, mem_we}, 32'd1);
    chk("we_ready_low", {31'd0, slave_ready}, 32'd0);
    chk("we_state", {29'd0, dbg_state}, 32'd3);
    @(negedge clk);
    chk("we_end", {31'd0, mem_we}, 32'd0);
    chk("we_ready_back", {31'd0, slave_ready}, 32'd1);
    chk("wr_q_drained", exp_q.size(), 32'd0);
  endtask

  task automatic send_read_addr(input logic [AW-1:0] a, input bit glitch);
    for (int i = AW - 1; i >= 0; i--)
      send_bit(a[i], (i == AW - 1) ? 1'b0 : glitch);
    @(negedge clk);
    chk("re_strobe", {31'd0, mem_re}, 32'd1);
    chk("re_addr", {20'd0, mem_addr}, {20'd0, a});
    chk("re_valid_low0", {31'd0, slave_valid}, 32'd0);
    @(negedge clk);
    chk("re_end", {31'd0, mem_re}, 32'd0);
    chk("re_valid_low1", {31'd0, slave_valid}, 32'd0);
    @(negedge clk);
    chk("rd_valid_rise", {31'd0, slave_valid}, 32'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int stall_bit, input int stall_len, input bit glitch);
    logic [DW-1:0] got;
    logic [DW-1:0] e;
    logic held;
    int re0;
    re0 = re_count;
    rd_exp_q.push_back(d);
    send_read_addr(a, glitch);
    for (int i = 0; i < DW; i++) begin
      if (i == stall_bit) begin
        master_ready = 1'b0;
        held = rd_bus;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          chk("stall_hold", {31'd0, rd_bus}, {31'd0, held});
          chk("stall_valid", {31'd0, slave_valid}, 32'd1);
        end
      end
      got[DW-1-i] = rd_bus;
      master_ready = 1'b1;
      @(negedge clk);
    end
    master_ready = 1'b0;
    chk("rd_valid_drop", {31'd0, slave_valid}, 32'd0);
    chk("rd_ready_back", {31'd0, slave_ready}, 32'd1);
    e = rd_exp_q.pop_front();
    chk("rd_data", {24'd0, got}, {24'd0, e});
    chk("re_once", re_count - re0, 32'd1);
  endtask

  // stimulus
  initial begin
    int re0;
    // reset block
    #1 rst = 1'b1;
    #1;
    chk("rst_ready", {31'd0, slave_ready}, 32'd0);
    chk("rst_valid", {31'd0, slave_valid}, 32'd0);
    chk("rst_rd_bus", {31'd0, rd_bus}, 32'd0);
    chk("rst_we_re", {30'd0, mem_we, mem_re}, 32'd0);
    chk("rst_addr", {20'd0, mem_addr}, 32'd0);
    chk("rst_state", {29'd0, dbg_state}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, slave_ready}, 32'd1);

    // plain write then plain read
    do_write(12'h5A3, 8'hC6, 1'b0);
    do_read(12'h012, 8'h3C, DW, 0, 1'b0);

    // stalled write and stalled read of the same word
    do_write(12'h0F0, 8'hA5, 1'b1);
    do_read(12'h0F0, 8'hA5, 2, 3, 1'b0);

    // timeout after a partial address
    re0 = re_count;
    for (int i = 0; i < 5; i++) send_bit(i[0], 1'b1);
    repeat (TO - 1) @(posedge clk);
    @(negedge clk);
    chk("to_not_yet", {29'd0, dbg_state}, 32'd1);
    @(negedge clk);
    chk("to_idle", {29'd0, dbg_state}, 32'd0);
    chk("to_no_re", re_count - re0, 32'd0);
    chk("to_ready", {31'd0, slave_ready}, 32'd1);
    do_write(12'h123, 8'h5E, 1'b0);

    // reset during the read data phase
    send_read_addr(12'h012, 1'b0);
    for (int i = 0; i < 3; i++) begin
      master_ready = 1'b1;
      @(negedge clk);
    end
    master_ready = 1'b0;
    chk("pre_rst_bit3", {31'd0, rd_bus}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'd0, slave_valid}, 32'd0);
    chk("mid_rst_rd_bus", {31'd0, rd_bus}, 32'd0);
    chk("mid_rst_ready", {31'd0, slave_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk("rel_ready", {31'd0, slave_ready}, 32'd1);
    chk("rel_state", {29'd0, dbg_state}, 32'd0);
    do_write(12'h321, 8'h9B, 1'b0);
    do_read(12'h321, 8'h9B, DW, 0, 1'b0);

    // mode toggled after the first beat stays a read
    do_read(12'h5A3, 8'hC6, DW, 0, 1'b1);
    do_read(12'h123, 8'h5E, 5, 2, 1'b1);

    repeat (3) @(negedge clk);
    chk("wr_q_empty_end", exp_q.size(), 32'd0);
    chk("no_ready_valid_overlap", {31'd0, overlap_seen}, 32'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_slave_port.md
# serial_slave_port

Slave-side endpoint of the serial system bus: the block the arbiter's per-slave port (`mode`, `wr_bus`, `master_valid`, `master_ready`, `rd_bus`, `slave_ready`, `slave_valid`) connects to. It deserialises an MSB-first address and, for writes, data from `wr_bus`. It performs one word access on a simple synchronous memory port. For reads, it serialises the returned word MSB-first on `rd_bus`. One instance sits in front of each slave's storage (S1/S2/S3).

## Interface
- ADDR_WIDTH, 12, serial address bits per transaction
- DATA_WIDTH, 8, data bits per word
- TIMEOUT, 16, idle cycles without a beat before a transaction is abandoned (≥2)

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- mode  in  1  1 = write, 0 = read; sampled on first address beat only
- wr_bus  in  1  serial address/write-data bit from master
- master_valid  in  1  wr_bus bit valid
- slave_ready  out  1  slave accepts wr_bus bit
- master_ready  in  1  master accepts rd_bus bit
- slave_valid  out  1  rd_bus bit valid
- rd_bus  out  1  serial read-data bit to master
- mem_addr  out  ADDR_WIDTH  registered address to storage
- mem_wdata  out  DATA_WIDTH  registered write data
- mem_we  out  1  one-cycle write strobe
- mem_re  out  1  one-cycle read strobe
- mem_rdata  in  DATA_WIDTH  read data, valid the cycle after mem_re

## Operation
- Inbound beat: `master_valid && slave_ready` at posedge. Outbound beat: `slave_valid && master_ready` at posedge.
- States: IDLE, ADDR, WDATA, WRITE, RFETCH, RLOAD, RDATA.
- IDLE: slave_ready=1. A beat shifts the bit into the address shift register, latches `mode`, sets bit count=1 and moves to ADDR.
- ADDR: slave_ready=1. Each beat shifts in one bit MSB-first. The ADDR_WIDTH-th beat goes to WDATA if latched mode=1, else RFETCH. Bit count resets to 0 on that transition.
- WDATA: slave_ready=1. Shifts DATA_WIDTH bits MSB-first. The last beat goes to WRITE.
- WRITE: slave_ready=0, mem_we=1 for exactly one cycle, then IDLE.
- RFETCH: mem_re=1 for one cycle, then RLOAD.
- RLOAD: captures mem_rdata into the output shift register, then RDATA.
- RDATA: slave_valid=1, rd_bus = shift register MSB. Each beat shifts left. The DATA_WIDTH-th beat goes to IDLE.
- mem_addr/mem_wdata hold their last value outside strobes.
- `mode` changes after the first beat are ignored.
- Bit counters are sized ceil(log2(max(ADDR_WIDTH,DATA_WIDTH)+1)) and never wrap within a phase.
- Timeout: an idle counter runs in ADDR, WDATA and RDATA. It clears on every beat and increments otherwise. When it reaches TIMEOUT the FSM returns to IDLE with no memory strobe, clears counters, and drops slave_valid.
- A partial transaction never issues mem_we or mem_re.

## Timing
- rst high: state=IDLE, all counters/shift registers 0. All outputs are 0 while rst is high, including slave_ready. slave_ready=1 from the first cycle after rst deasserts.
- Reset mid-transaction: outputs go to 0 asynchronously and no strobe completes.
- Write latency: mem_we is high in the cycle after the posedge accepting the last data bit. slave_ready is 0 in that same cycle. The next transaction's first beat can be accepted one cycle later.
- Read latency: mem_re is high in the cycle after the last address beat. slave_valid rises 2 cycles after the last address beat. It stays high, with rd_bus stable, until a beat occurs.
- Minimum transaction length, with no stalls:
  - write: ADDR_WIDTH+DATA_WIDTH+1 cycles;
  - read: ADDR_WIDTH+2+DATA_WIDTH cycles.
- Stalls of any length < TIMEOUT are lossless. A stall of exactly TIMEOUT cycles aborts.
- slave_ready and slave_valid are never high simultaneously.

## Test plan
- Write, no stalls: mode=1, addr 0x5A3, data 0xC6 → one cycle with mem_we=1, mem_addr=0x5A3, mem_wdata=0xC6, 1 cycle after the 20th beat; slave_ready=0 only that cycle.
- Read, no stalls: memory holds 0x3C at 0x012; mode=0, addr 0x012 → mem_re one cycle after the 12th beat; slave_valid rises 2 cycles after the 12th beat; rd_bus = 0,0,1,1,1,1,0,0 on 8 consecutive cycles; slave_valid=0 afterwards.
- Stalls: master_valid toggled every other cycle during a write of 0xA5 to 0x0F0, and master_ready low 3 cycles after read bit 2 → identical memory access; rd_bus holds bit 2 through the stall.
- Timeout: 5 address bits sent, then master_valid low → FSM back in IDLE after 16 cycles with no mem_we/mem_re; a following full write completes correctly.
- Reset mid-read: rst pulsed during RDATA bit 3 → slave_valid/rd_bus 0 immediately; slave_ready=1 the cycle after release; a new write succeeds.
- Mode glitch: mode=0 on the first beat, toggled to 1 during ADDR → transaction completes as a read; mem_we never asserts.
